// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the board UART receiver and transmitter.
//   - uart_state_e            : receiver frame-tracking states
//   - UART_DATA_BITS          : payload bits per frame (8N1)
//   - UART_FRAME_BITS         : start + data + stop bits on the wire
//   - UART_OVERSAMPLE_DEFAULT : baud_clock rising edges per bit period
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_FRAME_BITS         = 10;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Front end of the UART receiver: brings the asynchronous RX pad into the
// clock domain and turns the level-type baud_clock into a one-cycle tick.
// Ports:
//   clock      in  system clock, rising edge
//   reset      in  synchronous, active-low
//   baud_clock in  oversampled baud clock level, synchronous to clock
//   uart_rx    in  asynchronous serial line, idle high
//   rx_s       out uart_rx after a 2-FF synchronizer (resets to idle-high)
//   tick       out registered rising-edge strobe of baud_clock
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic baud_clock,
  input  logic uart_rx,
  output logic rx_s,
  output logic tick
);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic baud_q, baud_d;
  logic tick_q, tick_d;

  always_comb begin
    rx_meta_d = uart_rx;
    rx_s_d    = rx_meta_q;
    baud_d    = baud_clock;
    tick_d    = baud_clock & ~baud_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      // Reset high so a baud_clock already high at reset release is not
      // mistaken for a fresh edge.
      baud_q    <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      baud_q    <= baud_d;
      tick_q    <= tick_d;
    end
  end

  assign rx_s = rx_s_q;
  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// 8N1 UART receiver. Recovers start/8 data (LSB first)/stop frames from the
// RX pad using an oversampled baud clock, strobes each good byte and flags
// frames whose stop bit is low. A line held low after a framing error is
// treated as a break and must return high before another frame is accepted.
// Parameters:
//   OVERSAMPLE     baud_clock rising edges per bit period (even, 4..64)
// Ports:
//   clock          in  system clock, rising edge
//   reset          in  synchronous, active-low
//   baud_clock     in  OVERSAMPLE x baud rate, level signal
//   uart_rx        in  serial line, asynchronous, idle high
//   data           out last correctly received byte
//   data_valid     out one-cycle pulse, data updated this cycle
//   framing_error  out one-cycle pulse, stop bit sampled low
//   uart_busy      out high in every state except IDLE
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  each bit decision is the 2-of-3 majority of
//                             the samples at ticks mid-1, mid, mid+1; the
//                             decision (and strobes) move one tick later.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      baud_clock,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      uart_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LATE  = 1;
`else
  localparam int LATE  = 0;
`endif
  // Counter value seen on the deciding tick. The start bit is judged at its
  // middle; afterwards the counter restarts on every decision, so each later
  // decision lands exactly one bit period after the previous one.
  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(MID - 1 + LATE);
  localparam logic [CNT_W-1:0] BIT_DEC   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic rx_s;
  logic tick;

  uart_rx_sync u_sync (
    .clock      (clock),
    .reset      (reset),
    .baud_clock (baud_clock),
    .uart_rx    (uart_rx),
    .rx_s       (rx_s),
    .tick       (tick)
  );

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      data_valid_q, data_valid_d;
  logic                      framing_error_q, framing_error_d;

  logic [CNT_W-1:0]          dec_cnt;
  logic                      at_dec;
  logic                      sample;

  always_comb begin
    dec_cnt = (state_q == START) ? START_DEC : BIT_DEC;
    at_dec  = tick && (cnt_q == dec_cnt);
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two early votes are held; the third is the live sample on the deciding
  // tick.
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (tick && (cnt_q == dec_cnt - CNT_W'(2))) vote_d[0] = rx_s;
    if (tick && (cnt_q == dec_cnt - CNT_W'(1))) vote_d[1] = rx_s;
    sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
  end

  always_ff @(posedge clock) begin
    if (!reset) vote_q <= 2'b11;
    else        vote_q <= vote_d;
  end
`else
  always_comb begin
    sample = rx_s;
  end
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (at_dec) begin
          cnt_d = '0;
          // A start bit that is high again by mid-bit was a glitch.
          state_d = sample ? IDLE : DATA;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (at_dec) begin
          cnt_d     = '0;
          shift_d   = {sample, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (at_dec) begin
          cnt_d = '0;
          if (sample) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = BREAK;
          end
        end else if (tick) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BREAK: begin
        // Hold here until the line idles so a long low level cannot start
        // a stream of bogus frames.
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign uart_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
// Directed bench for uart_rx_frame at OVERSAMPLE=16. baud_clock is a
// one-clock pulse every 4 clocks, so one bit period is 64 clocks.
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;

  logic       clock      = 1'b0;
  logic       reset      = 1'b0;
  logic       baud_clock = 1'b0;
  logic       uart_rx    = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       uart_busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_rx_frame #(.OVERSAMPLE(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .baud_clock    (baud_clock),
    .uart_rx       (uart_rx),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .uart_busy     (uart_busy)
  );

  int div_cnt = 0;
  initial begin
    forever begin
      @(negedge clock);
      baud_clock = (div_cnt == 0);
      div_cnt    = (div_cnt + 1) % 4;
    end
  end

  // Strobe monitor
  int         valid_cnt   = 0;
  int         ferr_cnt    = 0;
  int         overlap_cnt = 0;
  int         wide_cnt    = 0;
  logic       prev_valid  = 1'b0;
  logic       prev_ferr   = 1'b0;
  logic [7:0] cap_q[$];

  always @(negedge clock) begin
    if (data_valid) begin
      valid_cnt++;
      cap_q.push_back(data);
      $display("rx byte %02h at %0t", data, $time);
    end
    if (framing_error) begin
      ferr_cnt++;
      $display("framing error strobe at %0t", $time);
    end
    if (data_valid && framing_error) overlap_cnt++;
    if ((data_valid && prev_valid) || (framing_error && prev_ferr)) wide_cnt++;
    prev_valid = data_valid;
    prev_ferr  = framing_error;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  // reset_bit >= 0 pulls reset low at the start of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int reset_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == reset_bit) reset = 1'b0;
      drive_bit(b[i]);
    end
    drive_bit(stop);
  endtask

  // Frame with a 4-clock (one tick) low pulse on data bit 2, placed over
  // the raw-line window that contains the single mid-bit sample point.
  task automatic send_glitch_frame(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        uart_rx = b[i];
        repeat (29) @(negedge clock);
        uart_rx = 1'b0;
        repeat (4) @(negedge clock);
        uart_rx = b[i];
        repeat (31) @(negedge clock);
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         v0;
    int         f0;
    logic [7:0] exp_glitch;
    logic [7:0] b_first;
    logic [7:0] b_second;

    vecs[0] = '{tx: 8'hA5, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'hA5};
    vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h00};
    vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'hFF};
    vecs[3] = '{tx: 8'h01, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h01};
    vecs[4] = '{tx: 8'h80, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h80};
    vecs[5] = '{tx: 8'h5A, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h5A};
    vecs[6] = '{tx: 8'h77, stop: 1'b0, exp_valid: 0, exp_ferr: 1, exp_data: 8'h5A};

    // Reset state
    reset = 1'b0;
    idle(10);
    check("reset_data", int'(data), 8'h00);
    check("reset_valid", int'(data_valid), 0);
    check("reset_ferr", int'(framing_error), 0);
    check("reset_busy", int'(uart_busy), 0);
    reset = 1'b1;
    idle(20);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].tx, vecs[i].stop, -1);
      uart_rx = 1'b1;
      idle(2 * BIT_CLKS);
      $display("vector %0d: tx %02h stop %0b -> data %02h busy %0b", i, vecs[i].tx,
               vecs[i].stop, data, uart_busy);
      check("vec_valid", valid_cnt - v0, vecs[i].exp_valid);
      check("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
      check("vec_data", int'(data), int'(vecs[i].exp_data));
    end

    // Back-to-back frames with no idle gap
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(2 * BIT_CLKS);
    $display("back-to-back: %0d strobes, data %02h", valid_cnt - v0, data);
    check("b2b_count", valid_cnt - v0, 2);
    if (cap_q.size() >= 2) begin
      b_first  = cap_q[cap_q.size() - 2];
      b_second = cap_q[cap_q.size() - 1];
    end else begin
      b_first  = 8'hxx;
      b_second = 8'hxx;
    end
    check("b2b_first", int'(b_first), 8'h00);
    check("b2b_second", int'(b_second), 8'hFF);

    // Short low pulse (4 ticks) is rejected at mid start bit
    v0 = valid_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    idle(8);
    check("glitch_busy_high", int'(uart_busy), 1);
    idle(8);
    uart_rx = 1'b1;
    idle(2 * BIT_CLKS);
    $display("start glitch: busy %0b data %02h", uart_busy, data);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_busy_low", int'(uart_busy), 0);

    // Framing error followed by a long break
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1);
    repeat (20 * BIT_CLKS) @(negedge clock);
    $display("break: busy %0b ferr strobes %0d data %02h", uart_busy, ferr_cnt - f0, data);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_data_kept", int'(data), 8'hFF);
    check("break_busy", int'(uart_busy), 1);
    uart_rx = 1'b1;
    idle(2 * BIT_CLKS);
    check("break_exit_busy", int'(uart_busy), 0);
    send_frame(8'h55, 1'b1, -1);
    idle(2 * BIT_CLKS);
    $display("after break: data %02h", data);
    check("after_break_valid", valid_cnt - v0, 1);
    check("after_break_data", int'(data), 8'h55);

    // Reset mid-frame (from data bit 4 to the end of the frame)
    v0 = valid_cnt;
    send_frame(8'h81, 1'b1, 4);
    uart_rx = 1'b1;
    idle(4);
    check("midreset_busy", int'(uart_busy), 0);
    reset = 1'b1;
    idle(2 * BIT_CLKS);
    $display("mid-frame reset: data %02h busy %0b", data, uart_busy);
    check("midreset_valid", valid_cnt - v0, 0);
    check("midreset_data", int'(data), 8'h00);
    send_frame(8'h81, 1'b1, -1);
    idle(2 * BIT_CLKS);
    $display("after reset: data %02h", data);
    check("postreset_valid", valid_cnt - v0, 1);
    check("postreset_data", int'(data), 8'h81);

    // One-tick glitch at mid of data bit 2
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_glitch = 8'hFF;
`else
    exp_glitch = 8'hFB;
`endif
    v0 = valid_cnt;
    send_glitch_frame(8'hFF);
    idle(2 * BIT_CLKS);
    $display("bit-2 glitch: data %02h", data);
    check("bitglitch_valid", valid_cnt - v0, 1);
    check("bitglitch_data", int'(data), int'(exp_glitch));

    // Strobe shape over the whole run
    check("strobe_overlap", overlap_cnt, 0);
    check("strobe_width", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Asynchronous serial receiver: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from a single RX line and presents each byte with a one-cycle valid strobe. It is the receive-side counterpart of the board UART transmitter and shares its idle-high line convention and its externally supplied baud-clock scheme. It samples at an oversampled baud clock and flags framing errors. The block sits between the pad and the command/host-interface logic.

## Interface
- OVERSAMPLE, 16, baud_clock rising edges per bit period; even, 4..64
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  reset, synchronous, active-low
- baud_clock  input  1  OVERSAMPLE × baud rate; level signal, rising edges detected internally; synchronous to clock
- uart_rx  input  1  serial line, asynchronous, idle high
- data  output  8  last correctly received byte
- data_valid  output  1  one-cycle pulse, data updated this cycle
- framing_error  output  1  one-cycle pulse, stop bit sampled low
- uart_busy  output  1  high while a frame is in progress (any state except IDLE)

## Operation
- uart_rx passes through a 2-FF synchronizer (reset value 1); FSM uses the second stage.
- tick = baud_clock high && previous-cycle baud_clock low; all counting is in ticks.
- tick counter width: clog2(OVERSAMPLE); bit counter 3 bits.
- IDLE: synchronized rx low → START, tick counter cleared.
- START: on tick OVERSAMPLE/2 (mid start bit) sample; low → DATA, counter cleared; high → IDLE (glitch rejection, no strobe).
- DATA: every OVERSAMPLE ticks sample, shift into bit 7 of shift register (right shift, LSB first); after 8th sample → STOP.
- STOP: OVERSAMPLE ticks later sample; high → data ← shift register, data_valid pulse, → IDLE; low → framing_error pulse, data unchanged, → BREAK.
- BREAK: wait until synchronized rx high, → IDLE. Prevents retrigger on a held-low line.
- Reset mid-frame: FSM → IDLE immediately, no strobe, partial byte discarded.
- data_valid and framing_error never assert in the same cycle.

## Timing
- Reset values: data 8'h00, data_valid 0, framing_error 0, uart_busy 0, synchronizer 1, state IDLE.
- rx edge to FSM: 2 clock cycles synchronizer latency; tick detection adds 1 cycle.
- data_valid / framing_error asserted the clock cycle after the stop-bit sampling tick is detected; high exactly one cycle.
- A new start edge is accepted in IDLE the cycle after the strobe; back-to-back frames with zero idle time are received without loss.
- uart_busy rises the cycle after START entry, falls with the return to IDLE (stays high through BREAK).
- Tolerated baud mismatch: ±(OVERSAMPLE/2 − 1)/(10·OVERSAMPLE) accumulated over the frame.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: each sample (start, data, stop) is the 2-of-3 majority of synchronized rx at ticks mid−1, mid, mid+1; decision taken at tick mid+1, so strobes move one tick later.
- Undefined: single sample at tick mid; no vote registers synthesized.

## Structure
- uart_pkg: state enum (IDLE, START, DATA, STOP, BREAK), UART_DATA_BITS = 8, UART_FRAME_BITS = 10, default OVERSAMPLE constant; shared with the transmitter.
- One sub-module: uart_rx_sync (2-FF synchronizer plus baud_clock edge detector, outputs rx_s and tick).

## Test plan
- 0xA5 frame at OVERSAMPLE=16 → single data_valid pulse, data = 0xA5, framing_error never high.
- Back-to-back 0x00 then 0xFF, no idle gap → two data_valid pulses, data 0x00 then 0xFF.
- rx low for 4 ticks then high → no strobe, uart_busy returns 0, FSM in IDLE.
- Frame 0x3C with stop bit low, line held low 20 bit periods → one framing_error pulse, data keeps previous value, no new frame until line high, then 0x55 received correctly.
- reset low at data bit 4 of 0x81, then released → no strobe; following 0x81 frame received correctly.
- With UART_RX_MAJORITY_VOTE_EN: one-tick low glitch at mid of bit 2 in 0xFF → data = 0xFF; without macro same stimulus → data = 0xFB.
